maxpool_2d_parallel_filters: RTL and testbench
==============================================

Name: maxpool_2d_parallel_filters

Overview:
Downstream consumer of tanh_2D_parallel_filters. Takes the full activation volume, FILTER_SIZE maps of IMAGE_SIZE x IMAGE_SIZE IEEE-754 single-precision words, and performs non-overlapping POOL_SIZE x POOL_SIZE max pooling on all filters in parallel. Windows are walked sequentially, one element per clock. A start/done handshake hands the pooled volume to the next layer (flatten/dense).

Parameters:
DATAWIDTH, 32, word width; fixed IEEE-754 binary32, and no other value is supported.
IMAGE_SIZE, 4, input map side; must be divisible by POOL_SIZE.
FILTER_SIZE, 2, number of maps processed in parallel.
POOL_SIZE, 2, window side and stride.

Ports:
clk  input  1  rising-edge clock.
reset  input  1  asynchronous, active-high reset.
enable  input  1  start request; sampled only in IDLE.
in_pool  input  [DATAWIDTH-1:0] x [FILTER_SIZE][IMAGE_SIZE][IMAGE_SIZE]  activation volume.
out_pool  output  [DATAWIDTH-1:0] x [FILTER_SIZE][IMAGE_SIZE/POOL_SIZE][IMAGE_SIZE/POOL_SIZE]  pooled volume.
busy  output  1  high while a pass is in progress.
done  output  1  one-cycle pulse; out_pool complete.

Behaviour:
- Clock is clk. Reset is reset: single clock domain; reset is asynchronous and active-high.
- Reset effects: state forced to IDLE; counters, accumulators and input buffer cleared; out_pool all 0x00000000; busy=0; done=0. Asserting reset mid-pass aborts the pass and no done is produced.
- States: IDLE, RUN, DONE.
- IDLE: on an edge with enable=1, capture in_pool into an internal buffer, clear counters (out_row, out_col, el_row, el_col), and go to RUN.
- After capture, in_pool may change freely.
- RUN: each cycle, for every filter f in parallel, read elem = buf[f][out_row*POOL_SIZE+el_row][out_col*POOL_SIZE+el_col].
  - First element of a window: acc <= elem.
  - Otherwise: acc <= fp32_max(acc, elem).
  - Last element of a window: out_pool[f][out_row][out_col] <= fp32_max(acc, elem).
- Counter order is raster within a window (el_col fastest, then el_row), then raster over windows (out_col, then out_row).
- RUN lasts exactly IMAGE_SIZE*IMAGE_SIZE cycles. After the final element, go to DONE.
- DONE: done=1 for exactly one cycle, then return to IDLE.
- Timing: done is high in the cycle beginning IMAGE_SIZE^2 edges after the accepting edge (16 for defaults).
- busy is registered: high from the edge after acceptance through the DONE cycle inclusive.
- enable is ignored while busy, including during DONE. If enable is held high, the next pass starts on the first IDLE edge, giving one idle cycle between passes.
- out_pool holds its value between passes. Words are overwritten window by window during RUN and are guaranteed consistent only from the done cycle until the next acceptance.
- fp32_max(a, b) returns b only if b is strictly greater than a; ties keep a, the earlier element.
  - Compare rules: sign-magnitude ordering; +0 and -0 are equal, so the first one seen is kept.
  - NaN (exp=0xFF, mantissa!=0) ranks below every number, so a NaN wins only if every element of the window is NaN.
  - +/-Inf are ordered normally. Denormals are compared by bit pattern, which is exact.

Decomposition:
- Shared package cnn_fp_pkg contains:
  - typedef fp32_t (logic [31:0]);
  - FP32_POS_ZERO and FP32_NEG_ZERO constants;
  - the function is_nan(fp32_t);
  - a state enum typedef for pooling stages.
- Sub-module fp32_max: purely combinational, 2 x fp32_t in, 1 out, implementing the ordering above. One instance per filter.

Test Plan:
1. Filter0 window(0,0) = 0x3F000000, 0x3F200000, 0x3F800000, 0x3F000000, start pulse -> out_pool[0][0][0]=0x3F800000; done exactly 16 cycles after the accepting edge, one cycle wide; busy covers the gap.
2. All-negative window 0xBF000000, 0xBF400000, 0xBE800000, 0xBF800000 -> 0xBE800000. Other filter fed the positive volume from scenario 1 -> independent correct results.
3. Signed zeros: window 0x80000000, 0x00000000, 0xBF800000, 0xBF800000 -> 0x80000000. Swap the first two -> 0x00000000.
4. NaN: window 0x7FC00000, 0x3F000000, 0xBF000000, 0x7FC00000 -> 0x3F000000. All four 0x7FC00000 -> 0x7FC00000.
5. Assert reset at RUN cycle 7 -> out_pool all zero, busy=0, no done. A fresh start afterwards -> correct full results.
6. enable held high for 3 passes, with in_pool changed mid-pass -> each pass uses the volume captured at its own acceptance; done pulses 18 cycles apart; enable pulsed during busy is ignored.

Source files
------------

// File: rtl/maxpool_2d_parallel_filters_pkg.sv
// Shared FP32 helpers for the CNN pooling stage: word type, signed-zero
// constants, NaN detection and the pooling FSM state encoding.
package cnn_fp_pkg;

    typedef logic [31:0] fp32_t;

    localparam fp32_t FP32_POS_ZERO = 32'h0000_0000;
    localparam fp32_t FP32_NEG_ZERO = 32'h8000_0000;

    typedef enum logic [1:0] {
        POOL_IDLE = 2'd0,
        POOL_RUN  = 2'd1,
        POOL_DONE = 2'd2
    } pool_state_t;

    function automatic logic is_nan(input fp32_t x);
        return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
    endfunction

endpackage

// File: rtl/maxpool_2d_parallel_filters_if.sv
// Start/done bus between the activation volume producer, the pooling block
// and the next layer, plus a debug view of the pooling FSM state.
interface maxpool_2d_parallel_filters_if #(
    parameter int DATAWIDTH   = 32,
    parameter int IMAGE_SIZE  = 4,
    parameter int FILTER_SIZE = 2,
    parameter int POOL_SIZE   = 2
);
    import cnn_fp_pkg::*;

    localparam int OUT_SIZE = IMAGE_SIZE / POOL_SIZE;

    // enable is a start request honoured only on an IDLE edge, where in_pool is
    // captured; busy stays high until the DONE cycle ends, and done pulses
    // once when every out_pool word of the pass has been written.
    logic                 enable;
    logic [DATAWIDTH-1:0] in_pool  [FILTER_SIZE][IMAGE_SIZE][IMAGE_SIZE];
    logic [DATAWIDTH-1:0] out_pool [FILTER_SIZE][OUT_SIZE][OUT_SIZE];
    logic                 busy;
    logic                 done;
    pool_state_t          state;

    modport master (output enable, in_pool, input out_pool, busy, done, state);
    modport slave  (input enable, in_pool, output out_pool, busy, done, state);

endinterface

// File: rtl/maxpool_2d_parallel_filters_fp32_max.sv
// Combinational FP32 max: returns b only when b is strictly greater than a;
// signed zeros tie, NaN ranks below every number.
module fp32_max
    import cnn_fp_pkg::*;
(
    input  fp32_t i_a,
    input  fp32_t i_b,
    output fp32_t o_max
);

    fp32_t w_key_a;
    fp32_t w_key_b;
    logic  w_take_b;

    // Maps sign-magnitude onto an unsigned scale; both zeros land on the bias.
    function automatic fp32_t order_key(input fp32_t x);
        return x[31] ? (FP32_NEG_ZERO - {1'b0, x[30:0]})
                     : (FP32_NEG_ZERO + {1'b0, x[30:0]});
    endfunction

    always_comb begin
        w_key_a  = order_key(i_a);
        w_key_b  = order_key(i_b);
        w_take_b = 1'b0;
        if (is_nan(i_b))
            w_take_b = 1'b0;
        else if (is_nan(i_a))
            w_take_b = 1'b1;
        else
            w_take_b = (w_key_b > w_key_a);
    end

    assign o_max = w_take_b ? i_b : i_a;

endmodule

// File: rtl/maxpool_2d_parallel_filters.sv
// Non-overlapping max pooling over all filter maps in parallel, walking each
// window one element per clock from a buffer captured at start.
module maxpool_2d_parallel_filters
    import cnn_fp_pkg::*;
#(
    parameter int DATAWIDTH   = 32,
    parameter int IMAGE_SIZE  = 4,
    parameter int FILTER_SIZE = 2,
    parameter int POOL_SIZE   = 2
) (
    input logic                           clk,
    input logic                           reset,
    maxpool_2d_parallel_filters_if.slave  bus
);

    localparam int OUT_SIZE = IMAGE_SIZE / POOL_SIZE;
    localparam int EW = (POOL_SIZE  > 1) ? $clog2(POOL_SIZE)  : 1;
    localparam int OW = (OUT_SIZE   > 1) ? $clog2(OUT_SIZE)   : 1;
    localparam int IW = (IMAGE_SIZE > 1) ? $clog2(IMAGE_SIZE) : 1;

    pool_state_t          r_state;
    logic                 r_busy;
    logic                 r_done;
    logic [EW-1:0]        r_el_row, r_el_col;
    logic [OW-1:0]        r_out_row, r_out_col;
    logic [DATAWIDTH-1:0] r_buf [FILTER_SIZE][IMAGE_SIZE][IMAGE_SIZE];
    logic [DATAWIDTH-1:0] r_acc [FILTER_SIZE];
    logic [DATAWIDTH-1:0] r_out [FILTER_SIZE][OUT_SIZE][OUT_SIZE];

    logic [IW-1:0]        w_row, w_col;
    logic                 w_first, w_last, w_last_win;
    fp32_t                w_elem [FILTER_SIZE];
    fp32_t                w_max  [FILTER_SIZE];
    fp32_t                w_win  [FILTER_SIZE];

    always_comb begin
        w_row      = IW'(r_out_row) * IW'(POOL_SIZE) + IW'(r_el_row);
        w_col      = IW'(r_out_col) * IW'(POOL_SIZE) + IW'(r_el_col);
        w_first    = (r_el_row == '0) && (r_el_col == '0);
        w_last     = (r_el_row == EW'(POOL_SIZE - 1)) && (r_el_col == EW'(POOL_SIZE - 1));
        w_last_win = (r_out_row == OW'(OUT_SIZE - 1)) && (r_out_col == OW'(OUT_SIZE - 1));
        for (int f = 0; f < FILTER_SIZE; f++) begin
            w_elem[f] = r_buf[f][w_row][w_col];
            // The first element of a window must not be compared against the stale accumulator.
            w_win[f]  = w_first ? w_elem[f] : w_max[f];
        end
    end

    for (genvar f = 0; f < FILTER_SIZE; f++) begin : g_max
        fp32_max u_max (
            .i_a   (r_acc[f]),
            .i_b   (w_elem[f]),
            .o_max (w_max[f])
        );
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= POOL_IDLE;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_el_row  <= '0;
            r_el_col  <= '0;
            r_out_row <= '0;
            r_out_col <= '0;
            for (int f = 0; f < FILTER_SIZE; f++) begin
                r_acc[f] <= FP32_POS_ZERO;
                for (int r = 0; r < IMAGE_SIZE; r++)
                    for (int c = 0; c < IMAGE_SIZE; c++)
                        r_buf[f][r][c] <= FP32_POS_ZERO;
                for (int r = 0; r < OUT_SIZE; r++)
                    for (int c = 0; c < OUT_SIZE; c++)
                        r_out[f][r][c] <= FP32_POS_ZERO;
            end
        end else begin
            case (r_state)
                POOL_IDLE: begin
                    if (bus.enable) begin
                        r_buf     <= bus.in_pool;
                        r_el_row  <= '0;
                        r_el_col  <= '0;
                        r_out_row <= '0;
                        r_out_col <= '0;
                        r_busy    <= 1'b1;
                        r_state   <= POOL_RUN;
                    end
                end
                POOL_RUN: begin
                    for (int f = 0; f < FILTER_SIZE; f++) begin
                        r_acc[f] <= w_win[f];
                        if (w_last)
                            r_out[f][r_out_row][r_out_col] <= w_win[f];
                    end
                    // Raster within the window, then raster over windows.
                    if (r_el_col == EW'(POOL_SIZE - 1)) begin
                        r_el_col <= '0;
                        if (r_el_row == EW'(POOL_SIZE - 1)) begin
                            r_el_row <= '0;
                            if (r_out_col == OW'(OUT_SIZE - 1)) begin
                                r_out_col <= '0;
                                r_out_row <= (r_out_row == OW'(OUT_SIZE - 1)) ? '0 : r_out_row + 1'b1;
                            end else begin
                                r_out_col <= r_out_col + 1'b1;
                            end
                        end else begin
                            r_el_row <= r_el_row + 1'b1;
                        end
                    end else begin
                        r_el_col <= r_el_col + 1'b1;
                    end
                    if (w_last && w_last_win) begin
                        r_done  <= 1'b1;
                        r_state <= POOL_DONE;
                    end
                end
                POOL_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= POOL_IDLE;
                end
                default: r_state <= POOL_IDLE;
            endcase
        end
    end

    assign bus.out_pool = r_out;
    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.state    = r_state;

endmodule

// File: tb/tb_maxpool_2d_parallel_filters.sv
// Directed bench for the parallel max-pool block: expected pooled words are
// queued at each start and compared against out_pool on every done pulse.
module tb_maxpool_2d_parallel_filters;
    import cnn_fp_pkg::*;

    localparam int DW = 32;
    localparam int IS = 4;
    localparam int FS = 2;
    localparam int PS = 2;
    localparam int OS = IS / PS;

    typedef logic [DW-1:0] vol_t [FS][IS][IS];

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    maxpool_2d_parallel_filters_if #(
        .DATAWIDTH(DW), .IMAGE_SIZE(IS), .FILTER_SIZE(FS), .POOL_SIZE(PS)
    ) bus ();

    maxpool_2d_parallel_filters #(
        .DATAWIDTH(DW), .IMAGE_SIZE(IS), .FILTER_SIZE(FS), .POOL_SIZE(PS)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [DW-1:0] exp_q[$];
    int n_vec = 0;
    int n_err = 0;
    vol_t v1, v2, v3, v4, va, vb, vc, vg;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp_v);
        n_vec++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp_v);
        end
    endtask

    // NaN sorts below everything; otherwise a signed magnitude value.
    function automatic longint rank(input logic [31:0] x);
        if (x[30:23] == 8'hFF && x[22:0] != 0) return -(longint'(1) << 40);
        return x[31] ? -longint'(x[30:0]) : longint'(x[30:0]);
    endfunction

    task automatic push_expected(input vol_t v);
        logic [31:0] best, e;
        for (int f = 0; f < FS; f++)
            for (int r = 0; r < OS; r++)
                for (int c = 0; c < OS; c++) begin
                    best = v[f][r*PS][c*PS];
                    for (int er = 0; er < PS; er++)
                        for (int ec = 0; ec < PS; ec++) begin
                            e = v[f][r*PS+er][c*PS+ec];
                            if (rank(e) > rank(best)) best = e;
                        end
                    exp_q.push_back(best);
                end
    endtask

    task automatic rand_vol(output vol_t v);
        for (int f = 0; f < FS; f++)
            for (int r = 0; r < IS; r++)
                for (int c = 0; c < IS; c++)
                    v[f][r][c] = $urandom();
    endtask

    task automatic set_win(inout vol_t v, input int f, input int wr, input int wc,
                           input logic [31:0] e0, input logic [31:0] e1,
                           input logic [31:0] e2, input logic [31:0] e3);
        v[f][wr*PS][wc*PS]     = e0;
        v[f][wr*PS][wc*PS+1]   = e1;
        v[f][wr*PS+1][wc*PS]   = e2;
        v[f][wr*PS+1][wc*PS+1] = e3;
    endtask

    task automatic compare_out(input string tag);
        logic [31:0] e;
        for (int f = 0; f < FS; f++)
            for (int r = 0; r < OS; r++)
                for (int c = 0; c < OS; c++) begin
                    e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
                    chk($sformatf("%s out[%0d][%0d][%0d]", tag, f, r, c), bus.out_pool[f][r][c], e);
                end
    endtask

    task automatic start_pass(input vol_t v);
        bus.in_pool = v;
        bus.enable  = 1'b1;
        tick();
        bus.enable  = 1'b0;
        push_expected(v);
    endtask

    // Waits for done counting cycles since the accepting edge, checks output at done.
    task automatic wait_done(input string tag, input int start_cyc);
        int cyc;
        int busy_bad;
        cyc = start_cyc;
        busy_bad = 0;
        while (bus.done !== 1'b1 && cyc < 60) begin
            if (bus.busy !== 1'b1) busy_bad++;
            tick();
            cyc++;
        end
        chk({tag, " latency"}, 32'(cyc), 32'd16);
        chk({tag, " busy_gap"}, 32'(busy_bad), 32'd0);
        chk({tag, " busy_at_done"}, 32'(bus.busy), 32'd1);
        compare_out(tag);
        tick();
        chk({tag, " done_width"}, 32'(bus.done), 32'd0);
        chk({tag, " busy_after"}, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        int ndone, c, last_done, dones_seen;

        reset      = 1'b1;
        bus.enable = 1'b0;
        rand_vol(vg);
        bus.in_pool = vg;
        tick();
        tick();
        for (int f = 0; f < FS; f++)
            for (int r = 0; r < OS; r++)
                for (int cc = 0; cc < OS; cc++)
                    chk($sformatf("rst out[%0d][%0d][%0d]", f, r, cc), bus.out_pool[f][r][cc], 32'h0);
        chk("rst busy", 32'(bus.busy), 32'd0);
        chk("rst done", 32'(bus.done), 32'd0);
        chk("rst state", 32'(bus.state), 32'(POOL_IDLE));
        reset = 1'b0;
        tick();

        // Positive window in filter 0.
        rand_vol(v1);
        set_win(v1, 0, 0, 0, 32'h3F000000, 32'h3F200000, 32'h3F800000, 32'h3F000000);
        start_pass(v1);
        chk("p1 busy_after_accept", 32'(bus.busy), 32'd1);
        wait_done("p1", 0);
        chk("p1 f0 w00", bus.out_pool[0][0][0], 32'h3F800000);

        // Negatives, signed zeros and NaN in filter 0; filter 1 gets pass-1 filter 0.
        rand_vol(v2);
        set_win(v2, 0, 0, 0, 32'hBF000000, 32'hBF400000, 32'hBE800000, 32'hBF800000);
        set_win(v2, 0, 0, 1, 32'h80000000, 32'h00000000, 32'hBF800000, 32'hBF800000);
        set_win(v2, 0, 1, 0, 32'h00000000, 32'h80000000, 32'hBF800000, 32'hBF800000);
        set_win(v2, 0, 1, 1, 32'h7FC00000, 32'h3F000000, 32'hBF000000, 32'h7FC00000);
        v2[1] = v1[0];
        start_pass(v2);
        wait_done("p2", 0);
        chk("p2 f0 neg", bus.out_pool[0][0][0], 32'hBE800000);
        chk("p2 f0 negzero_first", bus.out_pool[0][0][1], 32'h80000000);
        chk("p2 f0 poszero_first", bus.out_pool[0][1][0], 32'h00000000);
        chk("p2 f0 nan_mix", bus.out_pool[0][1][1], 32'h3F000000);
        chk("p2 f1 pos", bus.out_pool[1][0][0], 32'h3F800000);

        // All-NaN window, plus an enable pulse while busy that must be ignored.
        rand_vol(v3);
        set_win(v3, 0, 0, 0, 32'h7FC00000, 32'h7FC00000, 32'h7FC00000, 32'h7FC00000);
        start_pass(v3);
        for (int i = 0; i < 5; i++) tick();
        bus.enable = 1'b1;
        tick();
        bus.enable = 1'b0;
        wait_done("p3", 6);
        chk("p3 all_nan", bus.out_pool[0][0][0], 32'h7FC00000);
        tick();
        chk("p3 no_restart busy", 32'(bus.busy), 32'd0);
        chk("p3 no_restart state", 32'(bus.state), 32'(POOL_IDLE));

        // Reset in the middle of a pass.
        rand_vol(v4);
        start_pass(v4);
        exp_q.delete();
        for (int i = 0; i < 7; i++) tick();
        #2 reset = 1'b1;
        #2;
        for (int f = 0; f < FS; f++)
            for (int r = 0; r < OS; r++)
                for (int cc = 0; cc < OS; cc++)
                    chk($sformatf("abort out[%0d][%0d][%0d]", f, r, cc), bus.out_pool[f][r][cc], 32'h0);
        chk("abort busy", 32'(bus.busy), 32'd0);
        chk("abort state", 32'(bus.state), 32'(POOL_IDLE));
        tick();
        reset = 1'b0;
        dones_seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.done === 1'b1) dones_seen++;
            tick();
        end
        chk("abort no_done", 32'(dones_seen), 32'd0);
        rand_vol(v4);
        start_pass(v4);
        wait_done("p4", 0);

        // enable held high for three back-to-back passes, in_pool disturbed mid-pass.
        rand_vol(va);
        rand_vol(vb);
        rand_vol(vc);
        rand_vol(vg);
        push_expected(va);
        push_expected(vb);
        push_expected(vc);
        bus.in_pool = va;
        bus.enable  = 1'b1;
        tick();
        c = 0;
        ndone = 0;
        last_done = 0;
        while (ndone < 3 && c < 120) begin
            if (c == 5 || c == 23) bus.in_pool = vg;
            if (c == 9)  bus.in_pool = vb;
            if (c == 27) bus.in_pool = vc;
            if (bus.done === 1'b1) begin
                chk($sformatf("held done%0d time", ndone), 32'(c - last_done), (ndone == 0) ? 32'd16 : 32'd18);
                last_done = c;
                compare_out($sformatf("held%0d", ndone));
                ndone++;
                if (ndone == 3) bus.enable = 1'b0;
            end
            tick();
            c++;
        end
        chk("held pass_count", 32'(ndone), 32'd3);
        tick();
        chk("held stop busy", 32'(bus.busy), 32'd0);
        chk("queue drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
